bitmap_index_scanner: RTL

BITMAP_INDEX_SCANNER -- requirements
Module: bitmap_index_scanner

---
 rtl/bitmap_index_scanner.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/bitmap_index_scanner.sv
// bitmap_index_scanner
//   Accepts a WIDTH-bit bitmap and streams out the positions of its set bits,
//   lowest first, one index per accepted handshake. When the last index is
//   accepted, or when the scan is aborted, the block pulses done for one cycle.
//   done_count then reports how many indices were accepted downstream.
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : in_vec is presented (taken only in IDLE)
//   in_ready   : high in IDLE, when a new vector can be loaded
//   in_vec     : bitmap to scan
//   abort      : cancels the current scan (in IDLE it also blocks a load)
//   out_valid  : out_index/out_last are valid
//   out_ready  : downstream accepts out_index
//   out_index  : position of the lowest bit still pending
//   out_last   : out_index is the final pending bit
//   done       : one-cycle pulse when a scan completes or is aborted
//   done_count : indices accepted in the finished scan; held until next done
module bitmap_index_scanner #(
  parameter int WIDTH = 128,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             done,
  output logic [IDX_W-1:0] done_count
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] MASK_ONE = WIDTH'(1);
  localparam logic [IDX_W-1:0] CNT_ONE  = IDX_W'(1);

  state_t           r_state,      w_state_nxt;
  logic [WIDTH-1:0] r_mask,       w_mask_nxt;
  logic [IDX_W-1:0] r_cnt,        w_cnt_nxt;
  logic             r_done,       w_done_nxt;
  logic [IDX_W-1:0] r_done_count, w_done_count_nxt;

  logic [WIDTH-1:0] w_mask_rest;
  logic             w_mask_nz;
  logic             w_single;
  logic             w_xfer;
  logic [IDX_W-1:0] w_low_idx;
  logic [IDX_W-1:0] w_cnt_inc;

  // Subtracting one flips the lowest set bit and everything below it, so the
  // AND leaves the mask with exactly that lowest bit removed. If nothing is
  // left, the mask held a single bit.
  assign w_mask_nz   = |r_mask;
  assign w_mask_rest = r_mask & (r_mask - MASK_ONE);
  assign w_single    = w_mask_nz & ~(|w_mask_rest);
  assign w_cnt_inc   = r_cnt + CNT_ONE;

  // Lowest-set-bit encoder: scanning downward lets the lowest hit win.
  always_comb begin
    w_low_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (r_mask[i]) w_low_idx = IDX_W'(i);
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_SCAN) & w_mask_nz;
  assign out_index  = w_low_idx;
  assign out_last   = out_valid & w_single;
  assign done       = r_done;
  assign done_count = r_done_count;

  assign w_xfer = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_mask       <= '0;
      r_cnt        <= '0;
      r_done       <= 1'b0;
      r_done_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_mask       <= w_mask_nxt;
      r_cnt        <= w_cnt_nxt;
      r_done       <= w_done_nxt;
      r_done_count <= w_done_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_mask_nxt       = r_mask;
    w_cnt_nxt        = r_cnt;
    w_done_nxt       = 1'b0;
    w_done_count_nxt = r_done_count;

    case (r_state)
      S_IDLE: begin
        // abort while idle suppresses the load entirely
        if (in_valid && !abort) begin
          w_mask_nxt = in_vec;
          w_cnt_nxt  = '0;
          if (|in_vec) begin
            w_state_nxt = S_SCAN;
          end else begin
            // nothing to scan: finish immediately with an empty result
            w_done_nxt       = 1'b1;
            w_done_count_nxt = '0;
          end
        end
      end

      S_SCAN: begin
        // abort wins over a transfer in the same cycle, so that transfer
        // is not counted
        if (abort) begin
          w_mask_nxt       = '0;
          w_state_nxt      = S_IDLE;
          w_done_nxt       = 1'b1;
          w_done_count_nxt = r_cnt;
        end else if (w_xfer) begin
          w_mask_nxt = w_mask_rest;
          w_cnt_nxt  = w_cnt_inc;
          if (w_single) begin
            w_state_nxt      = S_IDLE;
            w_done_nxt       = 1'b1;
            w_done_count_nxt = w_cnt_inc;
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
